// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - rv32e execute stage: ALU decode, datapath, valid/ready handshake
// Define ALU_MEXT_EN to build the iterative multiply/divide unit for the M extension.
module alu_exec_unit #(
   parameter int XLEN    = 32,
   parameter int MUL_BPC = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);
   localparam int SW = $clog2(XLEN);
   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_LUI = 7'b0110111;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
      OP_SRA, OP_OR, OP_AND, OP_COPYB, OP_ILL, OP_MEXT
   } op_t;

   state_t          state;
   op_t             op;
   logic            accept;
   logic [SW-1:0]   shamt;
   logic [XLEN-1:0] sc_res;
   logic            m_special;
   logic [XLEN-1:0] m_special_res;
   logic            m_last;
   logic [XLEN-1:0] m_final;

   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign accept   = in_valid && in_ready;
   assign shamt    = op_b[SW-1:0];

   always_comb begin
      op = OP_ADD;
      case (alu_op)
         2'b00: op = OP_ADD;
         2'b01: op = OP_SUB;
         2'b11: op = (opcode == OPC_LUI) ? OP_COPYB : OP_ADD;
         default: begin
            if (opcode == OPC_R && funct7 == 7'b0000001) begin
`ifdef ALU_MEXT_EN
               op = OP_MEXT;
`else
               op = OP_ILL;
`endif
            end else if (opcode == OPC_R && funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
               op = OP_ILL;
            end else begin
               case (funct3)
                  3'b000: op = (funct7[5] && opcode == OPC_R) ? OP_SUB : OP_ADD;
                  3'b001: op = OP_SLL;
                  3'b010: op = OP_SLT;
                  3'b011: op = OP_SLTU;
                  3'b100: op = OP_XOR;
                  3'b101: op = funct7[5] ? OP_SRA : OP_SRL;
                  3'b110: op = OP_OR;
                  default: op = OP_AND;
               endcase
            end
         end
      endcase
   end

   always_comb begin
      sc_res = '0;
      case (op)
         OP_ADD:   sc_res = op_a + op_b;
         OP_SUB:   sc_res = op_a - op_b;
         OP_SLL:   sc_res = op_a << shamt;
         OP_SLT:   sc_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         OP_SLTU:  sc_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         OP_XOR:   sc_res = op_a ^ op_b;
         OP_SRL:   sc_res = op_a >> shamt;
         OP_SRA:   sc_res = XLEN'($signed(op_a) >>> shamt);
         OP_OR:    sc_res = op_a | op_b;
         OP_AND:   sc_res = op_a & op_b;
         OP_COPYB: sc_res = op_b;
         default:  sc_res = '0;
      endcase
   end

`ifdef ALU_MEXT_EN
   localparam logic [SW-1:0] MUL_LAST = SW'(XLEN / MUL_BPC - 1);
   localparam logic [SW-1:0] DIV_LAST = SW'(XLEN - 1);
   localparam logic [XLEN-1:0] SMIN   = {1'b1, {(XLEN-1){1'b0}}};

   logic              a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [2:0]        m_f3;
   logic [SW-1:0]     m_cnt;
   logic              m_neg_q, m_neg_r;
   logic [2*XLEN-1:0] m_acc, m_mcand, acc_nx, prod;
   logic [XLEN-1:0]   m_mplier, m_dquo, m_drem, m_dvsr, quo_nx, rem_nx;
   logic [XLEN:0]     d_tmp, d_diff;

   // Both units work on magnitudes; the sign is re-applied to the final value.
   always_comb begin
      a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
      b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      a_neg    = a_signed && op_a[XLEN-1];
      b_neg    = b_signed && op_b[XLEN-1];
      a_mag    = a_neg ? -op_a : op_a;
      b_mag    = b_neg ? -op_b : op_b;
      m_special = funct3[2] && ((op_b == '0) || (b_signed && op_a == SMIN && op_b == '1));
      if (op_b == '0)
         m_special_res = funct3[1] ? op_a : '1;
      else
         m_special_res = funct3[1] ? '0 : op_a;
   end

   always_comb begin
      acc_nx = m_acc;
      for (int j = 0; j < MUL_BPC; j++)
         if (m_mplier[j]) acc_nx = acc_nx + (m_mcand << j);
      d_tmp  = {m_drem, m_dquo[XLEN-1]};
      d_diff = d_tmp - {1'b0, m_dvsr};
      if (d_tmp >= {1'b0, m_dvsr}) begin
         rem_nx = d_diff[XLEN-1:0];
         quo_nx = {m_dquo[XLEN-2:0], 1'b1};
      end else begin
         rem_nx = d_tmp[XLEN-1:0];
         quo_nx = {m_dquo[XLEN-2:0], 1'b0};
      end
      prod = m_neg_q ? -acc_nx : acc_nx;
      if (!m_f3[2])
         m_final = (m_f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else if (m_f3[1])
         m_final = m_neg_r ? -rem_nx : rem_nx;
      else
         m_final = m_neg_q ? -quo_nx : quo_nx;
      m_last = (m_cnt == (m_f3[2] ? DIV_LAST : MUL_LAST));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_f3 <= '0; m_cnt <= '0; m_neg_q <= 1'b0; m_neg_r <= 1'b0;
         m_acc <= '0; m_mcand <= '0; m_mplier <= '0;
         m_dquo <= '0; m_drem <= '0; m_dvsr <= '0;
      end else if (accept && op == OP_MEXT && !m_special) begin
         m_f3     <= funct3;
         m_cnt    <= '0;
         m_neg_q  <= a_neg ^ b_neg;
         m_neg_r  <= a_neg;
         m_acc    <= '0;
         m_mcand  <= {{XLEN{1'b0}}, a_mag};
         m_mplier <= b_mag;
         m_dquo   <= a_mag;
         m_drem   <= '0;
         m_dvsr   <= b_mag;
      end else if (state == BUSY) begin
         m_cnt    <= m_cnt + 1'b1;
         m_acc    <= acc_nx;
         m_mcand  <= m_mcand << MUL_BPC;
         m_mplier <= m_mplier >> MUL_BPC;
         m_dquo   <= quo_nx;
         m_drem   <= rem_nx;
      end
   end
`else
   assign m_special     = 1'b0;
   assign m_special_res = '0;
   assign m_last        = 1'b0;
   assign m_final       = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
         illegal   <= 1'b0;
      end else if (accept) begin
         if (op == OP_MEXT && !m_special) begin
            state     <= BUSY;
            out_valid <= 1'b0;
         end else begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= (op == OP_MEXT) ? m_special_res : sc_res;
            zero      <= ((op == OP_MEXT) ? m_special_res : sc_res) == '0;
            illegal   <= (op == OP_ILL);
         end
      end else if (state == BUSY) begin
         if (m_last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= m_final;
            zero      <= (m_final == '0);
            illegal   <= 1'b0;
         end
      end else if (state == DONE && out_ready) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end
   end
endmodule
